// File: rtl/lcd_pkg.sv
// lcd_pkg: shared word format, idle value and arbiter FSM encoding.
// A word is {dc, byte}: dc=0 command, dc=1 pixel/parameter data.
package lcd_pkg;

  localparam int LCD_WORD_W = 9;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [LCD_WORD_W-1:0] DATA_IDLE = 9'h000;

  typedef logic [LCD_WORD_W-1:0] lcd_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/lcd_rr_pick.sv
// lcd_rr_pick: combinational winner select; index 0 has absolute priority,
// others round-robin from ptr over 1..NUM_REQ-1. Out: one-hot win, win_id.
module lcd_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDW-1:0]     win_id,
  output logic               pick_any
);

  logic [IDW-1:0] idx;

  always_comb begin
    win      = '0;
    win_id   = '0;
    pick_any = 1'b0;
    idx      = '0;
    if (elig[0]) begin
      win[0]   = 1'b1;
      pick_any = 1'b1;
    end
    // ptr always holds 1..NUM_REQ-1, so the walk starts at a valid index
    for (int k = 0; k < NUM_REQ-1; k++) begin
      idx = IDW'(1 + (int'(ptr) - 1 + k) % (NUM_REQ-1));
      if (!pick_any && elig[idx]) begin
        win[idx] = 1'b1;
        win_id   = idx;
        pick_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one lcd_write byte engine among NUM_REQ (<=4)
// requesters; whole-transaction grants, gap, init lock, wr_done watchdog.
module lcd_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GAP_CYC = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd2000,
  parameter logic [lcd_pkg::LCD_WORD_W-1:0] DATA_IDLE = lcd_pkg::DATA_IDLE
) (
  input  logic                    sys_clk_50MHz,
  input  logic                    sys_rst_n,
  input  logic                    init_done,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [9*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      wr_ack,
  output logic [8:0]              data,
  output logic                    en_write,
  input  logic                    wr_done,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic                    timeout_err
);

  import lcd_pkg::*;

  arb_state_e state, state_n;

  logic [NUM_REQ-1:0] elig, win;
  logic [NUM_REQ-1:0] gnt_n, ack_n;
  logic [1:0]  win_id, ptr, ptr_n, gid_n, nxt_ptr;
  logic        pick_any;
  logic [8:0]  data_n, own_word;
  logic        own_req, own_wr;
  logic        en_n, busy_n, tmo_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  gap_cnt, gap_n;
  logic        to_hit, gap_end, take;

  // Requesters other than lcd_init are locked out until init completes
  assign elig = req & {{(NUM_REQ-1){init_done}}, 1'b1};

  lcd_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (2)
  ) u_pick (
    .elig     (elig),
    .ptr      (ptr),
    .win      (win),
    .win_id   (win_id),
    .pick_any (pick_any)
  );

  always_comb begin
    own_req  = 1'b0;
    own_wr   = 1'b0;
    own_word = DATA_IDLE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 2'(i)) begin
        own_req  = req[i];
        own_wr   = req_wr[i];
        own_word = req_data[i*LCD_WORD_W +: LCD_WORD_W];
      end
    end
  end

  assign take    = own_req && own_wr;
  assign to_hit  = (cnt == TIMEOUT_CYC - 16'd1);
  assign gap_end = (gap_cnt == 8'(GAP_CYC-1));
  assign nxt_ptr = (int'(grant_id) >= NUM_REQ-1) ? 2'd1
                                                 : grant_id + 2'd1;

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      wr_ack      <= '0;
      en_write    <= 1'b0;
      data        <= DATA_IDLE;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      ptr         <= 2'd1;
      cnt         <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      wr_ack      <= ack_n;
      en_write    <= en_n;
      data        <= data_n;
      busy        <= busy_n;
      grant_id    <= gid_n;
      timeout_err <= tmo_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      gap_cnt     <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (pick_any) state_n = OWN;
      OWN: begin
        if (take)          state_n = WAIT;
        else if (!own_req) state_n = GAP;
      end
      WAIT: begin
        if (wr_done)     state_n = OWN;
        else if (to_hit) state_n = GAP;
      end
      GAP: if (gap_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_n  = gnt;
    ack_n  = '0;
    en_n   = 1'b0;
    data_n = data;
    gid_n  = grant_id;
    tmo_n  = timeout_err;
    ptr_n  = ptr;
    cnt_n  = cnt;
    gap_n  = gap_cnt;
    unique case (state)
      IDLE: begin
        gap_n = '0;
        if (pick_any) begin
          gnt_n = win;
          gid_n = win_id;
        end
      end
      OWN: begin
        if (take) begin
          data_n = own_word;
          en_n   = 1'b1;
          cnt_n  = '0;
        end else if (!own_req) begin
          gnt_n = '0;
          ptr_n = nxt_ptr;
          gap_n = '0;
        end
      end
      WAIT: begin
        // wr_done wins over a watchdog expiring in the same cycle
        if (wr_done) begin
          ack_n  = gnt;
          data_n = DATA_IDLE;
        end else if (to_hit) begin
          tmo_n  = 1'b1;
          gnt_n  = '0;
          ptr_n  = nxt_ptr;
          data_n = DATA_IDLE;
          gap_n  = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      GAP: gap_n = gap_cnt + 8'd1;
      default: ;
    endcase
  end

  assign busy_n = (state_n != IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: random/directed requesters, fake lcd_write, and a
// scoreboard checking grant order, words, acks, gap and watchdog.
module tb_lcd_bus_arbiter;

  localparam int N        = 3;
  localparam int GAP      = 4;
  localparam int TMO      = 2000;
  localparam int GNT_WAIT = 3000;
  localparam int ACK_WAIT = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done = 1'b0;
  logic       wr_done;
  logic [2:0] req = '0;
  logic [2:0] req_wr = '0;
  logic [8:0] rd [3];
  logic [26:0] req_data;
  logic [2:0] gnt, wr_ack;
  logic [8:0] data;
  logic       en_write, busy, timeout_err;
  logic [1:0] grant_id;

  assign req_data = {rd[2], rd[1], rd[0]};

  always #10 clk = ~clk;

  lcd_bus_arbiter #(
    .NUM_REQ     (N),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (16'(TMO)),
    .DATA_IDLE   (9'h000)
  ) dut (
    .sys_clk_50MHz (clk),
    .sys_rst_n     (rst_n),
    .init_done     (init_done),
    .req           (req),
    .req_wr        (req_wr),
    .req_data      (req_data),
    .gnt           (gnt),
    .wr_ack        (wr_ack),
    .data          (data),
    .en_write      (en_write),
    .wr_done       (wr_done),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_own[$];
  logic [8:0] exp_words[3][$];
  logic [8:0] fixed_w[4];
  int cur_own = 0;
  int outstanding = 0;
  int mptr = 1;
  int done_dly = 8;
  bit withhold = 1'b0;
  int dcnt = 0;
  logic [2:0] prev_gnt = '0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", nm, what);
  endtask

  // Reference arbitration: index 0 first, else first pending from mptr
  function automatic int pick(input logic [2:0] m);
    if (m[0]) return 0;
    for (int k = 0; k < N-1; k++) begin
      int c = (mptr - 1 + k) % (N-1) + 1;
      if ((m & (3'b001 << c)) != 0) return c;
    end
    return -1;
  endfunction

  task automatic plan(input logic [2:0] m);
    int o;
    while (m != 0) begin
      o = pick(m);
      exp_own.push_back(o);
      m = m & ~(3'b001 << o);
      mptr = o % (N-1) + 1;
    end
  endtask

  // Fake lcd_write: answers each en_write after done_dly cycles
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt    <= 0;
      wr_done <= 1'b0;
    end else begin
      if (en_write)      dcnt <= done_dly;
      else if (dcnt > 0) dcnt <= dcnt - 1;
      wr_done <= (dcnt == 1) && !en_write && !withhold;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if (gnt != prev_gnt && gnt != 3'b000) begin
        if (exp_own.size() == 0) begin
          fail("grant_unexpected", $sformatf("got gnt %0h, expected none", gnt));
        end else begin
          cur_own = exp_own.pop_front();
          chk("grant_onehot", 16'(gnt), 16'(3'b001 << cur_own));
          chk("grant_id", 16'(grant_id), 16'(cur_own));
        end
      end
      prev_gnt = gnt;
      if (en_write) begin
        chk("wr_owner", 16'(gnt), 16'(3'b001 << cur_own));
        if (exp_words[cur_own].size() == 0)
          fail("wr_unexpected", $sformatf("got word %0h, expected none", data));
        else
          chk("wr_data", 16'(data), 16'(exp_words[cur_own].pop_front()));
        outstanding++;
      end
      if (wr_ack != 3'b000) begin
        chk("ack_owner", 16'(wr_ack), 16'(3'b001 << cur_own));
        chk("ack_data_idle", 16'(data), 16'h000);
        if (outstanding == 0)
          fail("ack_spurious", $sformatf("got ack %0h, expected none", wr_ack));
        else
          outstanding--;
      end
    end
  end

  task automatic txn(input logic [1:0] id, input int nw, input bit early,
                     input bit tmo, input bit rnd);
    int t;
    logic [8:0] w[$];
    for (int k = 0; k < nw; k++) begin
      w.push_back(rnd ? 9'($urandom) : fixed_w[k]);
      exp_words[id].push_back(w[k]);
    end
    req[id] = 1'b1;
    t = 0;
    while (!gnt[id] && t < GNT_WAIT) begin
      req_wr[id] = 1'($urandom_range(0, 1));
      rd[id] = 9'($urandom);
      @(negedge clk);
      t++;
    end
    if (!gnt[id]) begin
      fail("gnt_wait", $sformatf("got no grant for %0d, expected one", id));
      req[id] = 1'b0;
      req_wr[id] = 1'b0;
      return;
    end
    for (int k = 0; k < nw; k++) begin
      rd[id] = w[k];
      req_wr[id] = 1'b1;
      @(negedge clk);
      req_wr[id] = 1'b0;
      if (early && k == nw-1) req[id] = 1'b0;
      if (tmo) begin
        t = 0;
        while (!timeout_err && t < TMO + 50) begin
          @(negedge clk);
          t++;
        end
        chk("timeout_latency", 16'(t), 16'(TMO));
        chk("timeout_gnt", 16'(gnt), 16'h0);
        outstanding = 0;
        withhold = 1'b0;
        req[id] = 1'b0;
        return;
      end
      t = 0;
      while (!wr_ack[id] && t < ACK_WAIT) begin
        @(negedge clk);
        t++;
      end
      if (!wr_ack[id]) begin
        fail("ack_wait", $sformatf("got no ack for %0d, expected one", id));
        req[id] = 1'b0;
        return;
      end
    end
    req[id] = 1'b0;
    @(negedge clk);
    chk("gnt_release", 16'(gnt[id]), 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected one");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t;
    logic [2:0] m;
    logic [8:0] w6;
    rd[0] = '0;
    rd[1] = '0;
    rd[2] = '0;
    fixed_w[0] = 9'h011;
    fixed_w[1] = 9'h136;
    fixed_w[2] = 9'h100;
    fixed_w[3] = 9'h000;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_ack", 16'(wr_ack), 16'h0);
    chk("rst_en", 16'(en_write), 16'h0);
    chk("rst_data", 16'(data), 16'h000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_gid", 16'(grant_id), 16'h0);
    chk("rst_tmo", 16'(timeout_err), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // init requester alone, fixed words, then gap length
    done_dly = 8;
    plan(3'b001);
    txn(2'd0, 3, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (busy && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("gap_len", 16'(t), 16'(GAP));

    // init lock
    req[1] = 1'b1;
    req[2] = 1'b1;
    repeat (20) @(negedge clk);
    chk("lock_gnt", 16'(gnt), 16'h0);
    chk("lock_busy", 16'(busy), 16'h0);
    init_done = 1'b1;
    plan(3'b110);
    fork
      txn(2'd1, 2, 1'b0, 1'b0, 1'b1);
      txn(2'd2, 2, 1'b0, 1'b0, 1'b1);
    join

    // no preemption; index 0 beats 1 at next arbitration
    plan(3'b100);
    fork
      txn(2'd2, 5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (25) @(negedge clk);
        plan(3'b011);
        fork
          txn(2'd0, 2, 1'b0, 1'b0, 1'b1);
          txn(2'd1, 2, 1'b0, 1'b0, 1'b1);
        join
      end
    join

    // req dropped while the last word is in flight
    plan(3'b010);
    txn(2'd1, 3, 1'b1, 1'b0, 1'b1);

    // watchdog
    withhold = 1'b1;
    plan(3'b110);
    fork
      txn(2'd2, 1, 1'b0, 1'b1, 1'b1);
      txn(2'd1, 2, 1'b0, 1'b0, 1'b1);
    join
    chk("tmo_sticky", 16'(timeout_err), 16'h1);

    // reset while a word is outstanding
    done_dly = 10;
    plan(3'b100);
    w6 = 9'($urandom);
    exp_words[2].push_back(w6);
    req[2] = 1'b1;
    t = 0;
    while (!gnt[2] && t < 50) begin
      @(negedge clk);
      t++;
    end
    rd[2] = w6;
    req_wr[2] = 1'b1;
    @(negedge clk);
    req_wr[2] = 1'b0;
    chk("rst_mid_en_before", 16'(en_write), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 16'(en_write), 16'h0);
    chk("rst_mid_gnt", 16'(gnt), 16'h0);
    chk("rst_mid_busy", 16'(busy), 16'h0);
    chk("rst_mid_data", 16'(data), 16'h000);
    chk("rst_mid_tmo", 16'(timeout_err), 16'h0);
    req[2] = 1'b0;
    outstanding = 0;
    mptr = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", 16'(busy), 16'h0);
    plan(3'b111);
    fork
      txn(2'd0, 2, 1'b0, 1'b0, 1'b1);
      txn(2'd1, 2, 1'b0, 1'b0, 1'b1);
      txn(2'd2, 2, 1'b0, 1'b0, 1'b1);
    join

    // random request sets
    for (int r = 0; r < 6; r++) begin
      done_dly = $urandom_range(1, 6);
      m = 3'($urandom_range(1, 7));
      plan(m);
      fork
        begin if (m[0]) txn(2'd0, $urandom_range(1, 4), 1'b0, 1'b0, 1'b1); end
        begin if (m[1]) txn(2'd1, $urandom_range(1, 4), 1'b0, 1'b0, 1'b1); end
        begin if (m[2]) txn(2'd2, $urandom_range(1, 4), 1'b0, 1'b0, 1'b1); end
      join
    end

    repeat (10) @(negedge clk);
    chk("left_grants", 16'(exp_own.size()), 16'h0);
    chk("left_words", 16'(exp_words[0].size() + exp_words[1].size()
                          + exp_words[2].size()), 16'h0);
    chk("left_acks", 16'(outstanding), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
